set_time_bank: RTL and testbench

//   Synchronous, parametrised time-setting bank: N_CH independent BCD hh:mm registers
//   (wall clock plus alarms), each adjusted by two active-low push buttons.

---
 rtl/set_time_pkg.sv | 49 ++++
 rtl/button_stepper.sv | 101 ++++++++++
 rtl/set_time_bank.sv | 144 ++++++++++++++
 tb/tb_set_time_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/set_time_pkg.sv
// Shared definitions for the time-setting bank.
//   hhmm_t       : one BCD hh:mm value, fields {h1,h0,m1,m0}, 24 h form
//   MIN_TENS_MAX : largest legal minute tens digit
//   HOUR_WRAP    : last legal hour before wrapping to 00
//   bcd_to_12h   : converts a 24 h BCD hour to its 12 h display form
//   hour_is_pm   : 1 when a 24 h BCD hour is 12 or later
package set_time_pkg;

  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam int         HOUR_WRAP    = 23;
  localparam logic [3:0] HOUR_WRAP_H1 = 4'(HOUR_WRAP / 10);
  localparam logic [3:0] HOUR_WRAP_H0 = 4'(HOUR_WRAP % 10);

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  // 00 -> 12, 13..23 -> 01..11, 01..12 unchanged. Returns {tens, units}.
  function automatic logic [7:0] bcd_to_12h(input logic [3:0] h1, input logic [3:0] h0);
    logic [4:0] hr;
    logic [4:0] h12;
    logic [3:0] tens;
    logic [3:0] units;
    hr = 5'(h1) * 5'd10 + 5'(h0);
    if (hr == 5'd0) begin
      h12 = 5'd12;
    end else if (hr > 5'd12) begin
      h12 = hr - 5'd12;
    end else begin
      h12 = hr;
    end
    if (h12 >= 5'd10) begin
      tens  = 4'd1;
      units = 4'(h12 - 5'd10);
    end else begin
      tens  = 4'd0;
      units = 4'(h12);
    end
    return {tens, units};
  endfunction

  function automatic logic hour_is_pm(input logic [3:0] h1, input logic [3:0] h0);
    return (h1 > 4'd1) || ((h1 == 4'd1) && (h0 >= 4'd2));
  endfunction

endpackage

// File: rtl/button_stepper.sv
// One push button turned into single-cycle step pulses.
//   clk   : clock
//   reset : synchronous, active-high
//   pin   : active-low asynchronous button
//   clear : restarts the hold counter (set disabled or channel changed)
//   step  : registered one-cycle pulse, one per press plus auto-repeat pulses
// A press is only recognised after the button has been seen released since
// reset, so a button held across reset produces nothing until re-pressed.
module button_stepper
  import set_time_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_DLY  = 50000,
  parameter int REPEAT_RATE = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic clear,
  output logic step
);

  localparam int CMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE);
  localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [FW-1:0]          fill_reg;
  logic                   prev_reg;
  logic                   armed_reg;
  logic                   rep_reg, rep_next;
  logic                   step_reg, step_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   level, held, fall;

  genvar gi;
  for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (reset) sync_reg[gi] <= 1'b1;
        else       sync_reg[gi] <= pin;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (reset) sync_reg[gi] <= 1'b1;
        else       sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign held  = armed_reg & ~level;
  assign fall  = held & prev_reg;

  // cnt_reg is 0 in the press cycle; the first repeat fires REPEAT_DLY-1
  // cycles later (the press cycle counts as held cycle 1), then every
  // REPEAT_RATE cycles.
  always_comb begin
    cnt_next  = cnt_reg;
    rep_next  = rep_reg;
    step_next = fall;
    if (!held || clear) begin
      cnt_next = '0;
      rep_next = 1'b0;
    end else if (!rep_reg && (cnt_reg == DLY_LAST)) begin
      step_next = 1'b1;
      rep_next  = 1'b1;
      cnt_next  = CW'(1);
    end else if (rep_reg && (cnt_reg == RATE_LAST)) begin
      step_next = 1'b1;
      cnt_next  = CW'(1);
    end else begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_reg  <= '0;
      prev_reg  <= 1'b1;
      armed_reg <= 1'b0;
      rep_reg   <= 1'b0;
      step_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      // The sync chain holds reset values until it has refilled with pin samples.
      if (fill_reg != FILL_DONE) fill_reg <= fill_reg + FW'(1);
      if ((fill_reg == FILL_DONE) && level) armed_reg <= 1'b1;
      prev_reg <= level;
      rep_reg  <= rep_next;
      step_reg <= step_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign step = step_reg;

endmodule

// File: rtl/set_time_bank.sv
// Bank of N_CH BCD hh:mm registers (ch0 clock, others alarms) set by a
// minute button (push2) and an hour button (push3).
//   clk, reset      : clock, synchronous active-high reset
//   switch          : set enable
//   sel             : channel being adjusted / displayed
//   push2, push3    : active-low minute / hour buttons
//   mode12          : 1 = 12 h display, 0 = 24 h display
//   time_bcd        : all channels, ch i at [16*i +: 16], 24 h {h1,h0,m1,m0}
//   disp_h1..disp_m0: selected channel, formatted per mode12
//   disp_pm         : selected channel hour >= 12
//   changed         : one-cycle pulse on the channel just incremented
module set_time_bank
  import set_time_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_DLY  = 50000,
  parameter int REPEAT_RATE = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 switch,
  input  logic [2:0]           sel,
  input  logic                 push2,
  input  logic                 push3,
  input  logic                 mode12,
  output logic [16*N_CH-1:0]   time_bcd,
  output logic [3:0]           disp_h1,
  output logic [3:0]           disp_h0,
  output logic [3:0]           disp_m1,
  output logic [3:0]           disp_m0,
  output logic                 disp_pm,
  output logic [N_CH-1:0]      changed
);

  localparam logic [3:0] N_CH_W = 4'(N_CH);

  hhmm_t [N_CH-1:0] time_reg;
  logic  [N_CH-1:0] changed_reg;
  logic  [2:0]      sel_reg;
  logic             sel_valid, clear, step_m, step_h;
  hhmm_t            cur;
  logic  [7:0]      h12;

  function automatic hhmm_t minute_step(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (t.m0 < 4'd9) begin
      r.m0 = t.m0 + 4'd1;
    end else begin
      r.m0 = 4'd0;
      r.m1 = (t.m1 < MIN_TENS_MAX) ? t.m1 + 4'd1 : 4'd0;
    end
    return r;
  endfunction

  function automatic hhmm_t hour_step(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (((t.h1 < HOUR_WRAP_H1) && (t.h0 == 4'd9)) ||
        ((t.h1 == HOUR_WRAP_H1) && (t.h0 == HOUR_WRAP_H0))) begin
      r.h0 = 4'd0;
      r.h1 = (t.h1 < HOUR_WRAP_H1) ? t.h1 + 4'd1 : 4'd0;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

  assign sel_valid = {1'b0, sel} < N_CH_W;
  // A channel switch or disabling set mode restarts any auto-repeat hold.
  assign clear = ~switch | (sel != sel_reg);

  always_ff @(posedge clk) begin
    if (reset) sel_reg <= 3'd0;
    else       sel_reg <= sel;
  end

  button_stepper #(
    .SYNC_STAGES(SYNC_STAGES), .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
  ) u_min (
    .clk(clk), .reset(reset), .pin(push2), .clear(clear), .step(step_m)
  );

  button_stepper #(
    .SYNC_STAGES(SYNC_STAGES), .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
  ) u_hour (
    .clk(clk), .reset(reset), .pin(push3), .clear(clear), .step(step_h)
  );

  // Steps arriving while gated are dropped, never queued.
  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_ch
    logic  take;
    hhmm_t nxt;
    assign take = switch & (sel == 3'(gi)) & (step_m | step_h);

    always_comb begin
      nxt = time_reg[gi];
      if (step_m) nxt = minute_step(nxt);
      if (step_h) nxt = hour_step(nxt);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        time_reg[gi]    <= '0;
        changed_reg[gi] <= 1'b0;
      end else begin
        if (take) time_reg[gi] <= nxt;
        changed_reg[gi] <= take;
      end
    end
  end

  assign time_bcd = time_reg;
  assign changed  = changed_reg;

  always_comb begin
    cur = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == 3'(i)) cur = time_reg[i];
    end
    h12     = bcd_to_12h(cur.h1, cur.h0);
    disp_pm = 1'b0;
    disp_h1 = 4'd0;
    disp_h0 = 4'd0;
    disp_m1 = 4'd0;
    disp_m0 = 4'd0;
    // Unselectable channel shows a blank 00:00 rather than 12:00 in 12 h mode.
    if (sel_valid) begin
      disp_pm = hour_is_pm(cur.h1, cur.h0);
      disp_m1 = cur.m1;
      disp_m0 = cur.m0;
      if (mode12) begin
        disp_h1 = h12[7:4];
        disp_h0 = h12[3:0];
      end else begin
        disp_h1 = cur.h1;
        disp_h0 = cur.h0;
      end
    end
  end

endmodule

// File: tb/tb_set_time_bank.sv
module tb_set_time_bank;

  localparam int N_CH        = 3;
  localparam int SYNC_STAGES = 2;
  localparam int REPEAT_DLY  = 8;
  localparam int REPEAT_RATE = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             switch = 1'b0;
  logic [2:0]       sel = 3'd0;
  logic             push2 = 1'b1;
  logic             push3 = 1'b1;
  logic             mode12 = 1'b0;
  logic [16*N_CH-1:0] time_bcd;
  logic [3:0]       disp_h1, disp_h0, disp_m1, disp_m0;
  logic             disp_pm;
  logic [N_CH-1:0]  changed;
  logic [15:0]      disp;

  int n_cmp = 0;
  int n_mis = 0;
  int pulses [N_CH] = '{default: 0};

  set_time_bank #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES),
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk(clk), .reset(reset), .switch(switch), .sel(sel),
    .push2(push2), .push3(push3), .mode12(mode12),
    .time_bcd(time_bcd),
    .disp_h1(disp_h1), .disp_h0(disp_h0), .disp_m1(disp_m1), .disp_m0(disp_m0),
    .disp_pm(disp_pm), .changed(changed)
  );

  always #5 clk = ~clk;

  assign disp = {disp_h1, disp_h0, disp_m1, disp_m0};

  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (changed[i]) pulses[i] <= pulses[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic h, input int len);
    push2 = ~m;
    push3 = ~h;
    tick(len);
    push2 = 1'b1;
    push3 = 1'b1;
    tick(6);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(4);
  endtask

  int p;
  logic [47:0] snap;

  initial begin
    tick(1);
    do_reset();
    chk("reset_time", time_bcd, 48'h0);
    chk("reset_changed", 48'(changed), 48'h0);

    // 1: minute presses on ch0, first one timed for latency
    switch = 1'b1;
    sel = 3'd0;
    tick(2);
    p = pulses[0];
    push2 = 1'b0;                 // sampled at the next rising edge t
    tick(3);                      // after t+2
    chk("lat_before", 48'(time_bcd[15:0]), 48'h0);
    chk("lat_before_chg", 48'(changed), 48'h0);
    tick(1);                      // after t+3
    chk("lat_digit", 48'(time_bcd[15:0]), 48'h0001);
    chk("lat_chg", 48'(changed), 48'h1);
    push2 = 1'b1;
    tick(1);
    chk("chg_one_cycle", 48'(changed), 48'h0);
    tick(6);
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 5);
    chk("t1_ch0", 48'(time_bcd[15:0]), 48'h0010);
    chk("t1_pulses", 48'(pulses[0] - p), 48'd10);

    // 2: ch1 up to 23:59, then both buttons together
    sel = 3'd1;
    tick(2);
    for (int i = 0; i < 23; i++) press(1'b1, 1'b1, 3);
    for (int i = 0; i < 36; i++) press(1'b1, 1'b0, 3);
    chk("t2_ch1_2359", 48'(time_bcd[31:16]), 48'h2359);
    p = pulses[1];
    press(1'b1, 1'b1, 3);
    chk("t2_ch1_wrap", 48'(time_bcd[31:16]), 48'h0000);
    chk("t2_one_pulse", 48'(pulses[1] - p), 48'd1);
    chk("t2_ch0_kept", 48'(time_bcd[15:0]), 48'h0010);

    // 3: auto-repeat on ch2
    sel = 3'd2;
    tick(2);
    p = pulses[2];
    push3 = 1'b0;
    tick(REPEAT_DLY + 3 * REPEAT_RATE);
    push3 = 1'b1;
    tick(6);
    chk("t3_hold_5", 48'(time_bcd[47:32]), 48'h0500);
    chk("t3_pulses_5", 48'(pulses[2] - p), 48'd5);
    p = pulses[2];
    push3 = 1'b0;
    tick(REPEAT_DLY + 3 * REPEAT_RATE - 1);
    push3 = 1'b1;
    tick(6);
    chk("t3_hold_4", 48'(time_bcd[47:32]), 48'h0900);
    chk("t3_pulses_4", 48'(pulses[2] - p), 48'd4);

    // 4: gating by switch and out-of-range sel
    snap = time_bcd;
    p = pulses[0] + pulses[1] + pulses[2];
    switch = 1'b0;
    press(1'b1, 1'b1, 3);
    chk("t4_sw0_time", time_bcd, snap);
    chk("t4_sw0_pulses", 48'(pulses[0] + pulses[1] + pulses[2] - p), 48'd0);
    switch = 1'b1;
    sel = 3'd3;
    tick(2);
    press(1'b1, 1'b1, 3);
    chk("t4_sel3_time", time_bcd, snap);
    chk("t4_sel3_pulses", 48'(pulses[0] + pulses[1] + pulses[2] - p), 48'd0);
    chk("t4_sel3_disp24", 48'(disp), 48'h0000);
    mode12 = 1'b1;
    tick(1);
    chk("t4_sel3_disp12", 48'(disp), 48'h0000);
    chk("t4_sel3_pm", 48'(disp_pm), 48'd0);
    mode12 = 1'b0;

    // 5: 12 h display
    do_reset();
    sel = 3'd0;
    tick(2);
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 3);
    mode12 = 1'b1;
    tick(1);
    chk("t5_0005_disp", 48'(disp), 48'h1205);
    chk("t5_0005_pm", 48'(disp_pm), 48'd0);
    mode12 = 1'b0;
    tick(1);
    chk("t5_0005_24h", 48'(disp), 48'h0005);
    for (int i = 0; i < 12; i++) press(1'b1, 1'b1, 3);
    for (int i = 0; i < 13; i++) press(1'b1, 1'b0, 3);
    mode12 = 1'b1;
    tick(1);
    chk("t5_1230_disp", 48'(disp), 48'h1230);
    chk("t5_1230_pm", 48'(disp_pm), 48'd1);
    press(1'b1, 1'b1, 3);
    for (int i = 0; i < 14; i++) press(1'b1, 1'b0, 3);
    chk("t5_1345_disp", 48'(disp), 48'h0145);
    chk("t5_1345_pm", 48'(disp_pm), 48'd1);
    mode12 = 1'b0;
    tick(1);
    chk("t5_1345_24h", 48'(disp), 48'h1345);
    chk("t5_1345_pm24", 48'(disp_pm), 48'd1);

    // 6: button held across reset
    push2 = 1'b0;
    tick(10);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("t6_after_reset", time_bcd, 48'h0);
    p = pulses[0];
    tick(30);
    chk("t6_held_time", time_bcd, 48'h0);
    chk("t6_held_pulses", 48'(pulses[0] - p), 48'd0);
    push2 = 1'b1;
    tick(6);
    chk("t6_release", time_bcd, 48'h0);
    press(1'b1, 1'b0, 3);
    chk("t6_repress", 48'(time_bcd[15:0]), 48'h0001);
    chk("t6_repress_pulse", 48'(pulses[0] - p), 48'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
